// File: rtl/codificador_de_inmediato.sv
// codificador_de_inmediato: turns a 32-bit constant plus a destination register
// into the shortest RV32I sequence that loads it (ADDI, LUI, or LUI+ADDI).
// The upper part is rounded so that LUI+ADDI with a sign-extended 12-bit
// immediate reconstructs the constant exactly.
// Optional feature: define CODIF_CONTADOR_EN to add the 16-bit saturating
// counter 'pares' of constants that needed a LUI+ADDI pair.
module codificador_de_inmediato #(
  parameter logic [6:0] OPC_LUI   = 7'b0110111,
  parameter logic [6:0] OPC_OPIMM = 7'b0010011
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] valor,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
`ifdef CODIF_CONTADOR_EN
  output logic [15:0] pares,
`endif
  output logic        ultimo
);

  typedef enum logic [1:0] {IDLE, EMIT_LUI, EMIT_ADDI} state_t;

  state_t      state_reg, state_next;
  logic [31:0] instr_reg, instr_next;
  logic        ultimo_reg, ultimo_next;
  logic        out_valid_reg, out_valid_next;
  logic [4:0]  rd_reg, rd_next;
  logic [11:0] lo_reg, lo_next;
  logic        need_addi_reg, need_addi_next;

  // Upper field rounded up when the low part will be sign-extended negative;
  // the carry out of bit 19 is dropped on purpose (wraps like the hardware).
  logic [19:0] hi_calc;
  logic [11:0] lo_calc;
  logic        accept;

  assign lo_calc = valor[11:0];
  assign hi_calc = valor[31:12] + {19'd0, valor[11]};
  assign in_ready = (state_reg == IDLE);
  assign accept = in_valid && in_ready;

  // Next-state and next-output logic; everything holds unless a handshake occurs.
  always_comb begin
    state_next     = state_reg;
    instr_next     = instr_reg;
    ultimo_next    = ultimo_reg;
    out_valid_next = out_valid_reg;
    rd_next        = rd_reg;
    lo_next        = lo_reg;
    need_addi_next = need_addi_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          rd_next        = rd;
          lo_next        = lo_calc;
          out_valid_next = 1'b1;
          if (hi_calc == 20'd0) begin
            state_next     = EMIT_ADDI;
            instr_next     = {lo_calc, 5'd0, 3'b000, rd, OPC_OPIMM};
            ultimo_next    = 1'b1;
            need_addi_next = 1'b0;
          end else begin
            state_next     = EMIT_LUI;
            instr_next     = {hi_calc, rd, OPC_LUI};
            need_addi_next = (lo_calc != 12'd0);
            ultimo_next    = (lo_calc == 12'd0);
          end
        end
      end
      EMIT_LUI: begin
        if (out_ready) begin
          if (need_addi_reg) begin
            state_next  = EMIT_ADDI;
            instr_next  = {lo_reg, rd_reg, 3'b000, rd_reg, OPC_OPIMM};
            ultimo_next = 1'b1;
          end else begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            ultimo_next    = 1'b0;
          end
        end
      end
      EMIT_ADDI: begin
        if (out_ready) begin
          state_next     = IDLE;
          out_valid_next = 1'b0;
          ultimo_next    = 1'b0;
        end
      end
      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
        ultimo_next    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any pending word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      instr_reg     <= 32'h0;
      ultimo_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      rd_reg        <= 5'd0;
      lo_reg        <= 12'd0;
      need_addi_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      instr_reg     <= instr_next;
      ultimo_reg    <= ultimo_next;
      out_valid_reg <= out_valid_next;
      rd_reg        <= rd_next;
      lo_reg        <= lo_next;
      need_addi_reg <= need_addi_next;
    end
  end

  assign instr     = instr_reg;
  assign ultimo    = ultimo_reg;
  assign out_valid = out_valid_reg;

`ifdef CODIF_CONTADOR_EN
  logic [15:0] pares_reg;

  // Count accepted constants that need both LUI and ADDI, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pares_reg <= 16'd0;
    end else if (accept && (hi_calc != 20'd0) && (lo_calc != 12'd0)
                 && (pares_reg != 16'hFFFF)) begin
      pares_reg <= pares_reg + 16'd1;
    end
  end

  assign pares = pares_reg;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_codificador_de_inmediato.sv
// Self-checking bench for codificador_de_inmediato: a queue-based reference
// model of the emitted words, a per-cycle compare process, directed cases with
// literal expectations and a randomized run with random backpressure.
module tb_codificador_de_inmediato;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] valor = 32'h0;
  logic [4:0]  rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic        ultimo;
`ifdef CODIF_CONTADOR_EN
  logic [15:0] pares;
  int          pares_model = 0;
`endif

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;   // 0: always ready, 1: random, 2: stall 3 cycles per word
  int stall_cnt = 0;
  bit checking = 1'b1;

  logic [32:0] exp_q[$];   // {ultimo, instr} words still to be emitted
  logic [32:0] hs_log[$];  // words actually taken by the consumer

  codificador_de_inmediato dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .valor(valor), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .instr(instr),
`ifdef CODIF_CONTADOR_EN
    .pares(pares),
`endif
    .ultimo(ultimo)
  );

  always #5 clk = ~clk;

  // Reference: LUI loads (valor + 0x800) >> 12 so that a sign-extended
  // low 12 bits added afterwards gives back valor exactly.
  function automatic void model_push(input logic [31:0] v, input logic [4:0] r);
    logic [31:0] rounded;
    logic [19:0] hi;
    logic [11:0] lo;
    rounded = v + 32'h800;
    hi = rounded[31:12];
    lo = v[11:0];
    if (hi == 20'd0) begin
      exp_q.push_back({1'b1, lo, 5'd0, 3'b000, r, 7'b0010011});
    end else if (lo == 12'd0) begin
      exp_q.push_back({1'b1, hi, r, 7'b0110111});
    end else begin
      exp_q.push_back({1'b0, hi, r, 7'b0110111});
      exp_q.push_back({1'b1, lo, r, 3'b000, r, 7'b0010011});
`ifdef CODIF_CONTADOR_EN
      if (pares_model != 65535) pares_model++;
`endif
    end
  endfunction

  // Record accepted requests into the model.
  always @(posedge clk) begin
    if (rst_n && in_valid && in_ready) model_push(valor, rd);
  end

  // Per-cycle comparison against the model queue.
  always @(negedge clk) begin
    if (rst_n && checking) begin
      tests++;
      if (out_valid !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL out_valid: got %b expected %b", out_valid, exp_q.size() != 0);
      end
      tests++;
      if (in_ready !== (exp_q.size() == 0)) begin
        fails++;
        $display("FAIL in_ready: got %b expected %b", in_ready, exp_q.size() == 0);
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        tests++;
        if ({ultimo, instr} !== exp_q[0]) begin
          fails++;
          $display("FAIL word: got ultimo=%b instr=%h expected ultimo=%b instr=%h",
                   ultimo, instr, exp_q[0][32], exp_q[0][31:0]);
        end
        if (out_ready) begin
          hs_log.push_back({ultimo, instr});
          void'(exp_q.pop_front());
          $display("[TB] handshake instr=%h ultimo=%b", instr, ultimo);
        end
      end
    end
  end

  // Consumer readiness driver.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (out_valid && stall_cnt < 3) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else begin
          out_ready = 1'b1;
          stall_cnt = 0;
        end
      end
    endcase
  end

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] v, input logic [4:0] r);
    int guard = 0;
    valor = v;
    rd = r;
    in_valid = 1'b1;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    $display("[TB] sent valor=%h rd=%0d", v, r);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || in_ready !== 1'b1) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got pending=%0d expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input logic [31:0] v, input logic [4:0] r, input int n,
                          input logic [32:0] w0, input logic [32:0] w1);
    hs_log.delete();
    send(v, r);
    wait_idle();
    check("handshake_count", 33'(hs_log.size()), 33'(n));
    if (hs_log.size() > 0) check("first_word", hs_log[0], w0);
    if (n > 1 && hs_log.size() > 1) check("second_word", hs_log[1], w1);
  endtask

  initial begin
    logic [31:0] v;
    int guard;
    // Reset values while rst_n is low.
    #2;
    check("reset_in_ready", {32'd0, in_ready}, 33'h1);
    check("reset_out_valid", {32'd0, out_valid}, 33'h0);
    check("reset_instr_ultimo", {ultimo, instr}, 33'h0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    ready_mode = 0;
    directed(32'h00000005, 5'd1, 1, {1'b1, 32'h00500093}, 33'h0);
    directed(32'hFFFFF800, 5'd1, 1, {1'b1, 32'h80000093}, 33'h0);
    directed(32'h12345000, 5'd2, 1, {1'b1, 32'h12345137}, 33'h0);
    directed(32'h12345FFF, 5'd3, 2, {1'b0, 32'h123461B7}, {1'b1, 32'hFFF18193});
    directed(32'hFFFFFFFF, 5'd4, 1, {1'b1, 32'hFFF00213}, 33'h0);
    directed(32'h7FFFF800, 5'd5, 2, {1'b0, 32'h800002B7}, {1'b1, 32'h80028293});
    directed(32'h00000000, 5'd6, 1, {1'b1, 32'h00000313}, 33'h0);

    // Backpressure: three stalled cycles at each word.
    ready_mode = 2;
    directed(32'h12345FFF, 5'd3, 2, {1'b0, 32'h123461B7}, {1'b1, 32'hFFF18193});

    // Reset between the LUI and ADDI handshakes.
    hs_log.delete();
    send(32'h12345FFF, 5'd3);
    guard = 0;
    while (hs_log.size() < 1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("lui_before_reset", 33'(hs_log.size()), 33'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_out_valid", {32'd0, out_valid}, 33'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_addi_after_reset", 33'(hs_log.size()), 33'd1);
    check("in_ready_after_reset", {32'd0, in_ready}, 33'h1);
    ready_mode = 0;
    directed(32'h00000000, 5'd0, 1, {1'b1, 32'h00000013}, 33'h0);

    // Randomized run with random backpressure and boundary-biased constants.
    ready_mode = 1;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0: v = 32'h0;
        1: v = 32'hFFFFFFFF;
        2: v = {$urandom_range(0, 1) != 0 ? 20'hFFFFF : 20'h00000, 12'($urandom)};
        3: v = {20'($urandom), 12'h000};
        4: v = {20'($urandom), 12'h800};
        default: v = $urandom;
      endcase
      send(v, 5'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    ready_mode = 0;
    wait_idle();
`ifdef CODIF_CONTADOR_EN
    check("pares_count", {17'd0, pares}, 33'(pares_model));
`endif
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
